// File: rtl/defines_package.sv
// Shared geometry types for the clip-and-split path, plus the stack reader's state encoding.
package defines_package;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D v0;
        Vertex3D v1;
        Vertex3D v2;
    } Triangle3D;

    typedef enum logic [1:0] {
        CSR_IDLE  = 2'd0,
        CSR_RUN   = 2'd1,
        CSR_DRAIN = 2'd2
    } csr_state_t;

endpackage

// File: rtl/cs_out_fifo.sv
// Small Triangle3D FIFO with an occupancy count; the head reads as zero while empty.
module cs_out_fifo
    import defines_package::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     wr_en,
    input  Triangle3D                wr_data,
    input  logic                     rd_en,
    output Triangle3D                rd_data,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int AW = $clog2(DEPTH);

    Triangle3D        mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            occ <= occ + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

    // Storage needs no reset: the head is masked until something is written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = (occ != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/cs_stack_reader.sv
// Pops triangles from the clip-and-split stack into a credit-limited output FIFO
// and hands them to rasterizer setup, with an enable-driven drain/done sequence.
module cs_stack_reader
    import defines_package::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  Triangle3D        stk_tri_out,
    input  logic             stk_empty,
    input  logic             stk_full,
    input  logic             stk_push,
    output logic             stk_pop,
    output Triangle3D        out_tri,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
    output logic             idle,
    output logic [CNT_W-1:0] tri_count
);

    localparam int OW = $clog2(BUF_DEPTH) + 1;

    csr_state_t      state;
    logic            in_flight;
    logic            accepted;
    logic            deq;
    logic            drain_done;
    logic [OW-1:0]   occ;
    logic [OW:0]     committed;
    logic [OW:0]     limit;

    assign out_valid = (occ != '0);
    assign deq       = out_valid && out_ready;

    // occ + in_flight - deq < BUF_DEPTH, rearranged so nothing can underflow.
    assign committed = {1'b0, occ} + (OW+1)'(in_flight);
    assign limit     = (OW+1)'(BUF_DEPTH) + (OW+1)'(deq);

    assign stk_pop  = (state == CSR_RUN) && en && !stk_empty && (committed < limit);
    // The stack favours a push taken in the same cycle and silently drops the pop.
    assign accepted = stk_pop && !(stk_push && !stk_full);

    // Drained once nothing is in flight and the FIFO empties by the end of this cycle.
    assign drain_done = !in_flight && (occ == OW'(deq));
    assign done       = (state == CSR_DRAIN) && drain_done;
    assign idle       = (state == CSR_IDLE) && (occ == '0) && !in_flight;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= CSR_IDLE;
            in_flight <= 1'b0;
            tri_count <= '0;
        end else begin
            in_flight <= accepted;
            if (deq) tri_count <= tri_count + CNT_W'(1);
            case (state)
                CSR_IDLE: if (en) begin
                    state     <= CSR_RUN;
                    tri_count <= '0;
                end
                CSR_RUN:   if (!en) state <= CSR_DRAIN;
                CSR_DRAIN: if (drain_done) state <= CSR_IDLE;
                default:   state <= CSR_IDLE;
            endcase
        end
    end

    cs_out_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (in_flight),
        .wr_data (stk_tri_out),
        .rd_en   (deq),
        .rd_data (out_tri),
        .occ     (occ)
    );

endmodule

// File: tb/tb_cs_stack_reader.sv
// Randomized and directed bench for cs_stack_reader against a queue-based stack and reader model.
module tb_cs_stack_reader;
    import defines_package::*;

    localparam int DEPTH   = 2;
    localparam int CNT_W   = 16;
    localparam int STK_CAP = 6;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             en = 1'b0;
    Triangle3D        stk_tri_out = '0;
    logic             stk_empty = 1'b1;
    logic             stk_full = 1'b0;
    logic             stk_push = 1'b0;
    logic             out_ready = 1'b0;
    logic             stk_pop;
    Triangle3D        out_tri;
    logic             out_valid;
    logic             done;
    logic             idle;
    logic [CNT_W-1:0] tri_count;

    cs_stack_reader #(.BUF_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .en          (en),
        .stk_tri_out (stk_tri_out),
        .stk_empty   (stk_empty),
        .stk_full    (stk_full),
        .stk_push    (stk_push),
        .stk_pop     (stk_pop),
        .out_tri     (out_tri),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done),
        .idle        (idle),
        .tri_count   (tri_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stack model: back of the queue is the top of stack.
    Triangle3D stk_q[$];
    Triangle3D push_data = '0;

    // Reader model: buffered triangles, one optional in-flight triangle, delivered count.
    int        m_state = M_IDLE;
    Triangle3D m_buf[$];
    bit        m_fly = 1'b0;
    Triangle3D m_fly_data = '0;
    int        m_cnt = 0;

    Triangle3D got_q[$];
    int        pop_cnt = 0;
    int        done_cnt = 0;

    function automatic Triangle3D rand_tri();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return Triangle3D'(r[$bits(Triangle3D)-1:0]);
    endfunction

    task automatic drive_stack();
        stk_empty = (stk_q.size() == 0);
        stk_full  = (stk_q.size() == STK_CAP);
    endtask

    task automatic preload(input Triangle3D t);
        stk_q.push_back(t);
        drive_stack();
    endtask

    task automatic step();
        bit acc, dq, pushed, exp_pop, exp_done;
        @(negedge clk);
        dq       = (m_buf.size() > 0) && out_ready;
        exp_pop  = (m_state == M_RUN) && en && !stk_empty &&
                   ((m_buf.size() + int'(m_fly) - int'(dq)) < DEPTH);
        exp_done = (m_state == M_DRAIN) && !m_fly && ((m_buf.size() - int'(dq)) == 0);
        chk("stk_pop", stk_pop, exp_pop);
        chk("out_valid", out_valid, m_buf.size() > 0);
        if (m_buf.size() > 0) chk("out_tri", out_tri, m_buf[0]);
        chk("tri_count", tri_count, CNT_W'(m_cnt));
        chk("done", done, exp_done);
        chk("idle", idle, (m_state == M_IDLE) && (m_buf.size() == 0) && !m_fly);
        chk("overflow", dut.in_flight && (dut.occ == DEPTH) && !dq, 1'b0);
        // The environment reacts to what the DUT actually requested.
        pushed = stk_push && !stk_full;
        acc    = stk_pop && !stk_empty && !pushed;
        if (out_valid && out_ready) got_q.push_back(out_tri);
        if (done) done_cnt++;
        if (acc) pop_cnt++;
        @(posedge clk);
        if (dq) begin
            m_buf.delete(0);
            m_cnt++;
        end
        if (m_fly) m_buf.push_back(m_fly_data);
        m_fly = acc;
        case (m_state)
            M_IDLE:  if (en) begin m_state = M_RUN; m_cnt = 0; end
            M_RUN:   if (!en) m_state = M_DRAIN;
            default: if (exp_done) m_state = M_IDLE;
        endcase
        if (pushed) stk_q.push_back(push_data);
        if (acc) m_fly_data = stk_q.pop_back();
        #1;
        stk_tri_out = acc ? m_fly_data : rand_tri();
        drive_stack();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_pop"}, stk_pop, 1'b0);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_tri"}, out_tri, '0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_idle"}, idle, 1'b1);
        chk({tag, "_cnt"}, tri_count, '0);
        chk({tag, "_fly"}, dut.in_flight, 1'b0);
        m_state = M_IDLE;
        m_buf.delete();
        m_fly = 1'b0;
        m_cnt = 0;
    endtask

    Triangle3D ta, tb, tc, tx, ty, td;
    Triangle3D p[5];

    initial begin
        drive_stack();
        #2;
        reset_checks("rst0");
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Three triangles, free-flowing output: LIFO order, 3 back-to-back pops.
        ta = rand_tri(); tb = rand_tri(); tc = rand_tri();
        preload(ta); preload(tb); preload(tc);
        out_ready = 1'b1;
        en = 1'b1;
        got_q.delete(); pop_cnt = 0;
        repeat (8) step();
        chk("t1_pops", pop_cnt, 3);
        chk("t1_count", tri_count, 3);
        chk("t1_n", got_q.size(), 3);
        chk("t1_o0", got_q.size() > 0 ? got_q[0] : '0, tc);
        chk("t1_o1", got_q.size() > 1 ? got_q[1] : '0, tb);
        chk("t1_o2", got_q.size() > 2 ? got_q[2] : '0, ta);

        // Back-pressure: only BUF_DEPTH pops, head held, then full in-order drain.
        out_ready = 1'b0;
        got_q.delete(); pop_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            p[i] = rand_tri();
            preload(p[i]);
        end
        repeat (8) step();
        chk("t2_pops", pop_cnt, DEPTH);
        chk("t2_valid", out_valid, 1'b1);
        chk("t2_head", out_tri, p[4]);
        out_ready = 1'b1;
        repeat (12) step();
        chk("t2_n", got_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("t2_order", got_q.size() > i ? got_q[i] : '0, p[4-i]);

        // Push colliding with pop: pop dropped, retry returns the pushed triangle.
        got_q.delete(); pop_cnt = 0;
        tx = rand_tri(); ty = rand_tri();
        preload(tx);
        stk_push = 1'b1; push_data = ty;
        step();
        stk_push = 1'b0;
        chk("t3_nofly", dut.in_flight, 1'b0);
        repeat (6) step();
        chk("t3_pops", pop_cnt, 2);
        chk("t3_o0", got_q.size() > 0 ? got_q[0] : '0, ty);
        chk("t3_o1", got_q.size() > 1 ? got_q[1] : '0, tx);

        // Empty stack while running, then a single push of D.
        got_q.delete();
        repeat (3) step();
        chk("t4_idle", idle, 1'b0);
        chk("t4_nopop", stk_pop, 1'b0);
        td = rand_tri();
        stk_push = 1'b1; push_data = td;
        step();
        stk_push = 1'b0;
        repeat (5) step();
        chk("t4_n", got_q.size(), 1);
        chk("t4_d", got_q.size() > 0 ? got_q[0] : '0, td);

        // Drop enable with one in flight and one buffered.
        got_q.delete(); pop_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 3; i++) preload(rand_tri());
        step(); step();
        chk("t5_fly", dut.in_flight, 1'b1);
        chk("t5_occ", dut.occ, 1);
        en = 1'b0;
        repeat (2) step();
        chk("t5_done", done_cnt, 1);
        chk("t5_idle", idle, 1'b1);
        repeat (3) step();
        chk("t5_once", done_cnt, 1);
        chk("t5_pops", pop_cnt, 2);
        chk("t5_n", got_q.size(), 2);
        stk_q.delete(); drive_stack();

        // Reset in the middle of a stream.
        en = 1'b1;
        for (int i = 0; i < 4; i++) preload(rand_tri());
        repeat (4) step();
        #2 n_rst = 1'b0;
        #1;
        reset_checks("rst1");
        en = 1'b0;
        @(posedge clk);
        #1;
        stk_tri_out = rand_tri();
        n_rst = 1'b1;
        repeat (4) step();
        chk("t6_novalid", out_valid, 1'b0);
        stk_q.delete(); drive_stack();

        // Random traffic across all states.
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 19) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            stk_push  = ($urandom_range(0, 2) == 0);
            push_data = rand_tri();
            step();
        end
        stk_push = 1'b0; en = 1'b0; out_ready = 1'b1;
        repeat (10) step();
        chk("final_idle", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
